// File: rtl/pipe_div_pkg.sv
// Shared types and constants for the pipelined restoring divider.
package pipe_div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DEFAULT_WIDTH = 32;
  localparam int MAX_WIDTH     = 64;

  // Divide-by-zero quotient; sliced down to the instance width.
  localparam logic [MAX_WIDTH-1:0] DIV_ZERO_QUOT = '1;

endpackage

// File: rtl/pipe_div_step.sv
// One restoring shift-subtract step: shifts the next dividend bit into the
// partial remainder and subtracts the divisor when it fits.
module pipe_div_step
  import pipe_div_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0] i_rem,
  input  logic             i_inBit,
  input  logic [WIDTH-1:0] i_divisor,
  output logic [WIDTH-1:0] o_rem,
  output logic             o_qBit
);

  logic [WIDTH:0]   w_shifted;
  logic [WIDTH-1:0] w_diff;
  logic             w_fits;

  // The shifted remainder needs one extra bit; whenever the divisor fits,
  // the difference is below the divisor and therefore fits in WIDTH bits.
  assign w_shifted = {i_rem, i_inBit};
  assign w_fits    = (w_shifted >= {1'b0, i_divisor});
  assign w_diff    = w_shifted[WIDTH-1:0] - i_divisor;
  assign o_rem     = w_fits ? w_diff : w_shifted[WIDTH-1:0];
  assign o_qBit    = w_fits;

endmodule

// File: rtl/pipe_div.sv
// Multi-cycle signed/unsigned divider (DIV/DIVU), one quotient bit per cycle.
// Optional macro DIV_EARLY_OUT_EN: trivial divisions skip the iteration phase.
module pipe_div
  import pipe_div_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic             sign_i,
  input  logic [WIDTH-1:0] dividend_i,
  input  logic [WIDTH-1:0] divisor_i,
  input  logic             cancel_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] quotient_o,
  output logic [WIDTH-1:0] remainder_o
);

  localparam logic [WIDTH-1:0] ZERO_QUOT = DIV_ZERO_QUOT[WIDTH-1:0];
  localparam logic [5:0]       LAST_STEP = 6'(WIDTH - 1);

  state_t           r_state;
  state_t           w_nextState;
  logic [5:0]       r_count;
  logic [WIDTH-1:0] r_quotShift;
  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_divisor;
  logic [WIDTH-1:0] r_dividendRaw;
  logic [WIDTH-1:0] r_quotient;
  logic [WIDTH-1:0] r_remainder;
  logic             r_quotNeg;
  logic             r_remNeg;
  logic             r_divZero;

  logic             w_accept;
  logic             w_lastStep;
  logic             w_qBit;
  logic             w_divZero;
  logic [WIDTH-1:0] w_absDividend;
  logic [WIDTH-1:0] w_absDivisor;
  logic [WIDTH-1:0] w_nextRem;
  logic [WIDTH-1:0] w_quotMag;
  logic [WIDTH-1:0] w_quotFinal;
  logic [WIDTH-1:0] w_remFinal;

  assign w_absDividend = (sign_i && dividend_i[WIDTH-1]) ? -dividend_i : dividend_i;
  assign w_absDivisor  = (sign_i && divisor_i[WIDTH-1])  ? -divisor_i  : divisor_i;
  assign w_divZero     = (divisor_i == '0);
  assign w_accept      = start_i && !cancel_i && (r_state != CALC);
  assign w_lastStep    = (r_state == CALC) && (r_count == LAST_STEP);

`ifdef DIV_EARLY_OUT_EN
  logic w_early;
  assign w_early = w_divZero || (w_absDividend < w_absDivisor);
`endif

  pipe_div_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .i_rem    (r_rem),
    .i_inBit  (r_quotShift[WIDTH-1]),
    .i_divisor(r_divisor),
    .o_rem    (w_nextRem),
    .o_qBit   (w_qBit)
  );

  // r_quotShift feeds dividend bits out of the top while quotient bits enter at the bottom.
  assign w_quotMag   = {r_quotShift[WIDTH-2:0], w_qBit};
  assign w_quotFinal = r_divZero ? ZERO_QUOT : (r_quotNeg ? -w_quotMag : w_quotMag);
  assign w_remFinal  = r_divZero ? r_dividendRaw : (r_remNeg ? -w_nextRem : w_nextRem);

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_comb begin
    w_nextState = r_state;
    if (cancel_i) begin
      w_nextState = IDLE;
    end else begin
      case (r_state)
        IDLE, DONE: begin
          if (start_i) begin
`ifdef DIV_EARLY_OUT_EN
            w_nextState = w_early ? DONE : CALC;
`else
            w_nextState = CALC;
`endif
          end else begin
            w_nextState = IDLE;
          end
        end
        CALC: begin
          if (w_lastStep) begin
            w_nextState = DONE;
          end
        end
        default: w_nextState = IDLE;
      endcase
    end
  end

  always_comb begin
    busy_o = (r_state != IDLE);
    done_o = (r_state == DONE);
  end

  // Results only change on a completed division, so a cancel leaves them intact.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_count       <= '0;
      r_quotShift   <= '0;
      r_rem         <= '0;
      r_divisor     <= '0;
      r_dividendRaw <= '0;
      r_quotient    <= '0;
      r_remainder   <= '0;
      r_quotNeg     <= 1'b0;
      r_remNeg      <= 1'b0;
      r_divZero     <= 1'b0;
    end else if (w_accept) begin
      r_count       <= '0;
      r_quotShift   <= w_absDividend;
      r_rem         <= '0;
      r_divisor     <= w_absDivisor;
      r_dividendRaw <= dividend_i;
      r_quotNeg     <= sign_i && (dividend_i[WIDTH-1] ^ divisor_i[WIDTH-1]);
      r_remNeg      <= sign_i && dividend_i[WIDTH-1];
      r_divZero     <= w_divZero;
`ifdef DIV_EARLY_OUT_EN
      if (w_early) begin
        r_quotient  <= w_divZero ? ZERO_QUOT : '0;
        r_remainder <= dividend_i;
      end
`endif
    end else if ((r_state == CALC) && !cancel_i) begin
      r_count     <= r_count + 6'd1;
      r_quotShift <= w_quotMag;
      r_rem       <= w_nextRem;
      if (w_lastStep) begin
        r_quotient  <= w_quotFinal;
        r_remainder <= w_remFinal;
      end
    end
  end

  assign quotient_o  = r_quotient;
  assign remainder_o = r_remainder;

endmodule

// File: doc/pipe_div.md
PIPE_DIV -- requirements
Module: pipe_div

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand and result width.
REQ-002 SHALL have port clk  input  1  single clock, all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous and active-low.
REQ-004 SHALL have port start_i  input  1  request a new division, sampled on the rising edge.
REQ-005 SHALL have port sign_i  input  1  1 = signed (DIV), 0 = unsigned (DIVU), sampled with start_i.
REQ-006 SHALL have port dividend_i  input  WIDTH  dividend (rs), sampled with start_i.
REQ-007 SHALL have port divisor_i  input  WIDTH  divisor (rt), sampled with start_i.
REQ-008 SHALL have port cancel_i  input  1  abort the current division (pipeline flush).
REQ-009 SHALL have port busy_o  output  1  unit occupied; EXE stalls while high.
REQ-010 SHALL have port done_o  output  1  one-cycle result-valid strobe.
REQ-011 SHALL have port quotient_o  output  WIDTH  quotient, destined for lo.
REQ-012 SHALL have port remainder_o  output  WIDTH  remainder, destined for hi.

Function
REQ-013 SHALL implement a 3-state FSM: IDLE, CALC, DONE.
REQ-014 SHALL set busy_o = (state != IDLE) and done_o = (state == DONE), both registered-state decodes.
REQ-015 In IDLE or DONE with start_i=1 and cancel_i=0, SHALL latch operand magnitudes, result signs and divisor-zero flag, clear a 6-bit iteration counter and enter CALC.
REQ-016 SHALL ignore start_i while in CALC.
REQ-017 In CALC, SHALL perform one restoring shift-subtract step per cycle, producing one quotient bit MSB-first.
REQ-018 After WIDTH steps, SHALL register the sign-corrected results into quotient_o/remainder_o and enter DONE.
REQ-019 Latency SHALL be WIDTH+1 cycles: done_o high exactly on the cycle WIDTH+1 edges after the edge that sampled start_i (33 for WIDTH=32).
REQ-020 DONE SHALL last exactly one cycle, then go to IDLE unless a new start is accepted (REQ-015).
REQ-021 quotient_o/remainder_o SHALL hold their values from DONE until the next result is registered.
REQ-022 Signed mode: quotient negative iff operand signs differ; remainder takes the dividend's sign.
REQ-023 Signed 0x80000000 / 0xFFFFFFFF SHALL yield quotient 0x80000000, remainder 0 (wrap, no trap).
REQ-024 Divisor zero SHALL yield quotient all-ones and remainder = dividend_i, in both modes.
REQ-025 cancel_i=1 SHALL force IDLE on the next edge from any state, suppress done_o and leave result outputs unchanged; cancel_i has priority over a simultaneous start_i.

Reset
REQ-026 With rst=0 at a rising edge: state IDLE, busy_o=0, done_o=0, quotient_o=0, remainder_o=0, counter=0.
REQ-027 Reset mid-CALC SHALL discard the division with no done_o pulse.

Configuration
REQ-028 Macro DIV_EARLY_OUT_EN defined: when divisor is zero or |dividend| < |divisor|, SHALL skip CALC, go directly to DONE with results registered, done_o asserted one cycle after start is sampled.
REQ-029 Macro undefined: every division, including these cases, SHALL take the full WIDTH+1 latency.

Structure
REQ-030 Package pipe_div_pkg SHALL hold the FSM state type, the WIDTH default, and the divide-by-zero quotient constant.
REQ-031 The single restoring step SHALL be a combinational sub-module pipe_div_step (partial remainder, divisor -> next remainder, quotient bit).

Verification
REQ-032 Unsigned 100/7, start at cycle 0 -> done_o at cycle 33 only, quotient 14, remainder 2; busy_o high cycles 1-33.
REQ-033 Signed -7/2 (0xFFFFFFF9 / 2) -> quotient 0xFFFFFFFD, remainder 0xFFFFFFFF; signed 0x80000000/0xFFFFFFFF -> 0x80000000, 0.
REQ-034 5/0, both modes -> quotient 0xFFFFFFFF, remainder 5; done_o at cycle 1 with DIV_EARLY_OUT_EN, cycle 33 without.
REQ-035 Start 1000/10, cancel_i at cycle 10 -> no done_o, outputs unchanged; start 9/3 at cycle 12 -> done_o at cycle 45, quotient 3, remainder 0.
REQ-036 rst=0 at cycle 20 of a division -> next cycle all outputs 0, state IDLE; start on the same cycle as a DONE is accepted back-to-back with correct second result.
